// File: rtl/mac_tree_ctrl_pkg.sv
// Shared types and default sizes for the MAC tree sequencer.
package mac_tree_ctrl_pkg;

  localparam int unsigned DefAddrW   = 10;
  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefPipeLat = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StResult,
    StDone
  } state_e;

endpackage

// File: rtl/mac_tree_addr_gen.sv
// Beat counter, linear activation address and tile index for the MAC tree sequencer.
module mac_tree_addr_gen
  import mac_tree_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              job_clr_i,   // new job: everything back to zero
  input  logic              k_clr_i,     // new tile: beat counter back to zero
  input  logic              step_i,      // one streamed beat
  input  logic              tile_adv_i,  // result accepted, more tiles follow
  output logic [CNT_W-1:0]  k_o,
  output logic [ADDR_W-1:0] act_addr_o,
  output logic [CNT_W-1:0]  tile_o
);

  logic [CNT_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] act_q, act_d;
  logic [CNT_W-1:0]  tile_q, tile_d;

  // Next-state: job clear dominates; activation address wraps naturally.
  always_comb begin
    k_d    = k_q;
    act_d  = act_q;
    tile_d = tile_q;
    if (job_clr_i) begin
      k_d    = '0;
      act_d  = '0;
      tile_d = '0;
    end else begin
      if (k_clr_i) begin
        k_d = '0;
      end else if (step_i) begin
        k_d   = k_q + CNT_W'(1);
        act_d = act_q + ADDR_W'(1);
      end
      if (tile_adv_i) begin
        tile_d = tile_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q    <= '0;
      act_q  <= '0;
      tile_q <= '0;
    end else begin
      k_q    <= k_d;
      act_q  <= act_d;
      tile_q <= tile_d;
    end
  end

  assign k_o        = k_q;
  assign act_addr_o = act_q;
  assign tile_o     = tile_q;

endmodule

// File: rtl/mac_tree_ctrl.sv
// Sequencer for the pipelined MAC tree: clear, stream K beats, drain, present result, per tile.
// Optional performance counters are built when MAC_TREE_CTRL_PERF_EN is defined.
module mac_tree_ctrl
  import mac_tree_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned PIPE_LAT = DefPipeLat
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_k_tiles,
  input  logic [CNT_W-1:0]  cfg_n_tiles,
  input  logic [7:0]        cfg_shift,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              wet_rd_en,
  output logic [ADDR_W-1:0] wet_rd_addr,
  output logic              PE_mac_enable,
  output logic              PE_clear_acc,
  output logic [7:0]        PE_res_shift_num,
  output logic              feed_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_tile_idx
`ifdef MAC_TREE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int unsigned DrainW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]  k_cfg_q, n_cfg_q;
  logic [7:0]        shift_q;
  logic              zero_done_q, zero_done_d;

  logic              start_acc;
  logic              cfg_zero;
  logic              run_start;
  logic              drain_last;
  logic              feed_last;
  logic              tile_last;
  logic              tile_adv;
  logic [CNT_W-1:0]  k_cnt;
  logic [CNT_W-1:0]  tile_cnt;

  assign start_acc  = (state_q == StIdle) && start;
  assign cfg_zero   = (cfg_k_tiles == '0) || (cfg_n_tiles == '0);
  // An empty job never leaves IDLE, so nothing on the datapath side moves.
  assign run_start  = start_acc && !cfg_zero;
  assign drain_last = (drain_q == DrainW'(PIPE_LAT - 1));
  assign feed_last  = (k_cnt == k_cfg_q - CNT_W'(1));
  assign tile_last  = (tile_cnt == n_cfg_q - CNT_W'(1));
  assign tile_adv   = (state_q == StResult) && res_ready && !tile_last;

  // Next-state logic and drain cycle counter.
  always_comb begin
    state_d     = state_q;
    drain_d     = '0;
    zero_done_d = start_acc && cfg_zero;
    unique case (state_q)
      StIdle:   if (run_start) state_d = StClear;
      StClear:  state_d = StFeed;
      StFeed:   if (feed_last) state_d = StDrain;
      StDrain: begin
        if (drain_last) state_d = StResult;
        else            drain_d = drain_q + DrainW'(1);
      end
      StResult: if (res_ready) state_d = tile_last ? StDone : StClear;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, drain counter and job configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      drain_q     <= '0;
      zero_done_q <= 1'b0;
      k_cfg_q     <= '0;
      n_cfg_q     <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      zero_done_q <= zero_done_d;
      if (run_start) begin
        k_cfg_q <= cfg_k_tiles;
        n_cfg_q <= cfg_n_tiles;
        shift_q <= cfg_shift;
      end
    end
  end

  // Output decode; purely from state so an asynchronous reset drops everything at once.
  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone) || zero_done_q;
    PE_mac_enable = (state_q != StIdle);
    PE_clear_acc  = (state_q == StClear);
    act_rd_en     = (state_q == StFeed);
    wet_rd_en     = (state_q == StFeed);
    feed_zero     = (state_q == StDrain) || (state_q == StResult);
    res_valid     = (state_q == StResult);
  end

  assign PE_res_shift_num = shift_q;
  assign res_tile_idx     = tile_cnt;
  assign wet_rd_addr      = ADDR_W'(k_cnt);

  mac_tree_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .job_clr_i  (run_start),
    .k_clr_i    (state_q == StClear),
    .step_i     (state_q == StFeed),
    .tile_adv_i (tile_adv),
    .k_o        (k_cnt),
    .act_addr_o (act_rd_addr),
    .tile_o     (tile_cnt)
  );

`ifdef MAC_TREE_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating busy/stall counters, cleared by any accepted start.
  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (start_acc) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy && (perf_busy_q != '1)) begin
        perf_busy_d = perf_busy_q + 32'd1;
      end
      if ((state_q == StResult) && !res_ready && (perf_stall_q != '1)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: doc/mac_tree_ctrl.md
Name: mac_tree_ctrl

Overview:
- Sequencer for the pipelined MAC tree datapath.
- Runs a job of N output tiles. For each tile it:
  - clears the accumulators,
  - streams K activation/weight beats from the buffer SRAMs (1-cycle read latency),
  - flushes the adder pipeline with zero products,
  - presents the result with a valid/ready handshake.
- Sits between the top-level job/config interface, the activation/weight SRAMs and the MAC tree.

Parameters:
- ADDR_W, 10, activation/weight SRAM address width.
- CNT_W, 16, width of the tile-count config fields.
- PIPE_LAT, 8, drain cycles from the last read to a stable tree output (SRAM read + input reg + multiply + ACCU_NUM_LOG2=4 adder stages + accumulate + saturate, minus overlap).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- cfg_k_tiles  in  CNT_W  beats per output tile (K).
- cfg_n_tiles  in  CNT_W  output tiles per job (N).
- cfg_shift  in  8  result right-shift amount.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse at job end.
- act_rd_en  out  1  activation SRAM read enable.
- act_rd_addr  out  ADDR_W  activation address; linear counter 0..N*K-1.
- wet_rd_en  out  1  weight SRAM read enable.
- wet_rd_addr  out  ADDR_W  weight address; equals k index 0..K-1.
- PE_mac_enable  out  1  tree enable.
- PE_clear_acc  out  1  tree accumulator clear.
- PE_res_shift_num  out  8  latched cfg_shift.
- feed_zero  out  1  forces tree weight inputs to 0; aligned to data arrival (1 cycle after rd_en).
- res_valid  out  1  tile result stable on tree outputs.
- res_ready  in  1  consumer accepts the result.
- res_tile_idx  out  CNT_W  index of the tile being presented.

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; latched config 0. Reset asserted mid-job aborts the job: no done pulse, SRAM enables drop immediately (asynchronous).
- Config latch: cfg_* are latched on the accepted start. Later changes to cfg_* have no effect until the next job.
- start outside IDLE is ignored.
- Zero-size job: start with K==0 or N==0 → done pulses the next cycle, busy stays 0, and no datapath signal toggles.
- State sequence: IDLE → CLEAR → FEED → DRAIN → RESULT → (CLEAR for the next tile | DONE) → IDLE.
- CLEAR (1 cycle): PE_clear_acc=1, PE_mac_enable=1.
- FEED (K cycles):
  - act_rd_en=wet_rd_en=1;
  - wet_rd_addr=k, with k counting 0..K-1;
  - act_rd_addr increments every beat.
- DRAIN (PIPE_LAT cycles): rd_en=0, feed_zero=1.
- RESULT:
  - res_valid=1; feed_zero stays 1, so the accumulator sees only zero adds and the output stays stable.
  - Transfer completes on the cycle with res_valid && res_ready.
  - If tile_idx==N-1 the FSM goes to DONE; otherwise it increments tile_idx and goes to CLEAR.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Tree enable: PE_mac_enable=1 in every state except IDLE. The tree is never frozen mid-tile, because its output accumulator keeps adding its last stage whenever the tree is enabled and not cleared.
- Latency: accepted start at edge 0 gives CLEAR in cycle 1, FEED in cycles 2..K+1, DRAIN for PIPE_LAT cycles, res_valid first in cycle K+PIPE_LAT+2.
- res_ready held low stalls the FSM in RESULT indefinitely; all outputs are held during the stall.
- Counters: act address wraps modulo 2^ADDR_W (no error flag); k and tile counters are CNT_W wide and never overflow, since they are bounded by K and N.

Optional Feature:
- Macro: MAC_TREE_CTRL_PERF_EN.
- When defined, adds two outputs:
  - perf_busy_cycles [31:0]: counts cycles with busy=1.
  - perf_stall_cycles [31:0]: counts RESULT cycles with res_ready=0.
- Both counters clear on an accepted start and saturate at all-ones.
- When undefined, the ports and logic are absent.

Decomposition:
- Package mac_tree_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, FEED, DRAIN, RESULT, DONE);
  - default PIPE_LAT;
  - the CNT_W/ADDR_W defaults.
- One natural sub-module, mac_tree_addr_gen, holds the k counter, linear activation address and tile index, with clear/step/advance-tile inputs from the FSM.

Test Plan:
- Basic tile: K=4, N=1, shift=0, all act=1, all wet=1, 16-wide tree, res_ready=1 → CLEAR in c1; FEED c2–c5 with addresses 0..3; DRAIN c6–c13; res_valid in c14; every row result is 64; done pulses in c15.
- Multi-tile with stall: K=2, N=3, res_ready low for 5 cycles on tile 1 → act_rd_addr runs 0..5; res_tile_idx runs 0,1,2; outputs are stable during the stall; exactly one done pulse.
- Shift and saturation: K=8, act=127, wet=127, shift=4 → 8*16*16129=2064512, >>4 = 129032, result saturates to 127 on every row.
- Zero config: start with K=0, N=5 → done pulses 1 cycle later; no rd_en, clear or enable activity.
- Reset mid-FEED: reset_n low during beat 2 → all outputs 0 immediately. A new job afterwards with K=4, N=1 → addresses restart at 0 and the result is correct (64).
- Start while busy is ignored; with MAC_TREE_CTRL_PERF_EN, the basic-tile job gives perf_busy_cycles=15 and the stall case gives perf_stall_cycles=5.
